// File: rtl/gpu_issue_pkg.sv
// Shared issue/dispatch definitions: warp and unit sizing, the functional-unit
// state encoding and the completion entry carried back to the issue side.
package gpu_issue_pkg;

    localparam int W     = 32;
    localparam int U     = 6;
    localparam int WID   = $clog2(W);
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } unit_state_e;

    typedef struct packed {
        logic [WID-1:0] warp_id;
        logic [U-1:0]   unit;
    } cpl_entry_t;

    // True when exactly one bit of the unit vector is set.
    function automatic logic is_onehot(input logic [U-1:0] v);
        return (v != '0) && ((v & (v - U'(1))) == '0);
    endfunction

    // A programmed latency of zero still needs one execute cycle.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
        return (l == '0) ? LAT_W'(1) : l;
    endfunction

endpackage

// File: rtl/fu_dispatch_receiver_rr_push_arb.sv
// Round-robin grant among N requesters. The search starts at the priority
// pointer; after a grant the pointer moves to the slot after the winner.
module rr_push_arb #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer wins, wrapping past N-1.
    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q) + k) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_d    = IW'((idx + 1) % N);
                end
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fu_dispatch_receiver.sv
// Functional-unit side of the warp dispatch interface. Each unit runs an
// IDLE/EXEC/DONE FSM with a fixed programmable latency; finished units are
// arbitrated round-robin into a completion queue drained by a valid/ready
// writeback port that also releases the warp's scoreboard bit.
// Optional: define CQ_BYPASS_EN to let a granted completion skip an empty
// queue and appear on the writeback port in the same cycle.
module fu_dispatch_receiver
    import gpu_issue_pkg::*;
#(
    parameter int CQ_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_valid,
    input  logic [WID-1:0]     disp_warp_id,
    input  logic [U-1:0]       disp_unit,
    input  logic [U*LAT_W-1:0] unit_lat,
    output logic [U-1:0]       unit_avail,
    output logic               disp_err,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [WID-1:0]     wb_warp_id,
    output logic [U-1:0]       wb_unit,
    output logic [W-1:0]       sb_release,
    output logic               cq_full
);
    localparam int PW    = $clog2(CQ_DEPTH);
    localparam int CNT_W = PW + 1;

    unit_state_e      state_q [U];
    unit_state_e      state_d [U];
    logic [LAT_W-1:0] cnt_q   [U];
    logic [LAT_W-1:0] cnt_d   [U];
    logic [WID-1:0]   wid_q   [U];
    logic [WID-1:0]   wid_d   [U];

    logic [U-1:0]     accept;
    logic [U-1:0]     done_req;
    logic [U-1:0]     gnt;
    logic             disp_err_q, disp_err_d;

    cpl_entry_t       mem_q [CQ_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, q_pop, grant_en, hs;
    cpl_entry_t       gnt_entry, wb_entry;

    // Decode the dispatch: accepted only if one-hot and aimed at an idle unit.
    always_comb begin
        accept = '0;
        if (disp_valid && is_onehot(disp_unit)) accept = disp_unit & unit_avail;
        disp_err_d = disp_valid && (accept == '0);
    end

    // Per-unit next-state and counter logic.
    always_comb begin
        for (int u = 0; u < U; u++) begin
            state_d[u] = state_q[u];
            cnt_d[u]   = cnt_q[u];
            wid_d[u]   = wid_q[u];
            case (state_q[u])
                ST_IDLE: begin
                    if (accept[u]) begin
                        state_d[u] = ST_EXEC;
                        cnt_d[u]   = eff_lat(unit_lat[u*LAT_W +: LAT_W]);
                        wid_d[u]   = disp_warp_id;
                    end
                end
                ST_EXEC: begin
                    cnt_d[u] = cnt_q[u] - LAT_W'(1);
                    if (cnt_q[u] == LAT_W'(1)) state_d[u] = ST_DONE;
                end
                ST_DONE: begin
                    if (gnt[u]) state_d[u] = ST_IDLE;
                end
                default: state_d[u] = ST_IDLE;
            endcase
        end
    end

    // Per-unit state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int u = 0; u < U; u++) begin
                state_q[u] <= ST_IDLE;
                cnt_q[u]   <= '0;
            end
        end else begin
            for (int u = 0; u < U; u++) begin
                state_q[u] <= state_d[u];
                cnt_q[u]   <= cnt_d[u];
            end
        end
    end

    // Captured warp ids are payload only; they are always rewritten on accept.
    always_ff @(posedge clk) begin
        for (int u = 0; u < U; u++) wid_q[u] <= wid_d[u];
    end

    // Per-unit outputs decoded from the registered state only.
    always_comb begin
        for (int u = 0; u < U; u++) begin
            unit_avail[u] = (state_q[u] == ST_IDLE);
            done_req[u]   = (state_q[u] == ST_DONE);
        end
    end

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign full     = (count_q == CNT_W'(CQ_DEPTH));
    assign empty    = (count_q == '0);
    assign q_pop    = !empty && wb_ready;
    assign grant_en = !full || q_pop;
    assign cq_full  = full;

    rr_push_arb #(
        .N (U)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (grant_en),
        .req (done_req),
        .gnt (gnt)
    );

    // Build the completion entry of the granted unit.
    always_comb begin
        gnt_entry.warp_id = '0;
        gnt_entry.unit    = gnt;
        for (int u = 0; u < U; u++) begin
            if (gnt[u]) gnt_entry.warp_id = gnt_entry.warp_id | wid_q[u];
        end
    end

    // Writeback source selection and queue push decision.
    always_comb begin
`ifdef CQ_BYPASS_EN
        wb_valid = !empty || (gnt != '0);
        wb_entry = empty ? gnt_entry : mem_q[rd_ptr_q];
        push     = (gnt != '0) && !(empty && wb_ready);
`else
        wb_valid = !empty;
        wb_entry = mem_q[rd_ptr_q];
        push     = (gnt != '0);
`endif
        wb_warp_id = wb_entry.warp_id;
        wb_unit    = wb_entry.unit;
        hs         = wb_valid && wb_ready;
        sb_release = hs ? (W'(1) << wb_warp_id) : '0;
    end

    // Queue pointers and occupancy; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (q_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, q_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= gnt_entry;
    end

    // Rejected-dispatch pulse, one cycle after the offending strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) disp_err_q <= 1'b0;
        else      disp_err_q <= disp_err_d;
    end

    assign disp_err = disp_err_q;

endmodule

// File: tb/tb_fu_dispatch_receiver.sv
// Bench for fu_dispatch_receiver: a transaction-level model (per-unit finish
// time, completion count, round-robin pointer) fills an expectation queue; a
// negedge monitor compares the DUT status and writeback port against it.
module tb_fu_dispatch_receiver;
    import gpu_issue_pkg::*;

    localparam int D = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               disp_valid = 1'b0;
    logic [WID-1:0]     disp_warp_id = '0;
    logic [U-1:0]       disp_unit = '0;
    logic [U*LAT_W-1:0] unit_lat = '0;
    logic [U-1:0]       unit_avail;
    logic               disp_err;
    logic               wb_valid;
    logic               wb_ready = 1'b0;
    logic [WID-1:0]     wb_warp_id;
    logic [U-1:0]       wb_unit;
    logic [W-1:0]       sb_release;
    logic               cq_full;

    fu_dispatch_receiver #(.CQ_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_warp_id (disp_warp_id),
        .disp_unit    (disp_unit),
        .unit_lat     (unit_lat),
        .unit_avail   (unit_avail),
        .disp_err     (disp_err),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_warp_id   (wb_warp_id),
        .wb_unit      (wb_unit),
        .sb_release   (sb_release),
        .cq_full      (cq_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int wid;
        int unit;
    } exp_t;

    exp_t exp_q[$];
    bit   m_busy    [U];
    int   m_done_at [U];
    int   m_wid     [U];
    int   m_ptr;
    int   m_count;
    bit   m_err;
    int   edge_n;

    always @(posedge clk or negedge rst) begin
        int  legal_u;
        int  g;
        int  idx;
        int  lat;
        bit  pop;
        if (!rst) begin
            for (int u = 0; u < U; u++) m_busy[u] = 1'b0;
            m_ptr   = 0;
            m_count = 0;
            m_err   = 1'b0;
            edge_n  = 0;
            exp_q.delete();
        end else begin
            legal_u = -1;
            if (disp_valid && $countones(disp_unit) == 1) begin
                for (int u = 0; u < U; u++)
                    if (disp_unit[u] && !m_busy[u]) legal_u = u;
            end
            m_err = disp_valid && (legal_u < 0);
            pop = wb_ready && (m_count > 0);
            g = -1;
            if (m_count < D || pop) begin
                for (int k = 0; k < U; k++) begin
                    idx = (m_ptr + k) % U;
                    if (g < 0 && m_busy[idx] && edge_n >= m_done_at[idx]) g = idx;
                end
            end
            if (g >= 0) begin
                exp_q.push_back('{wid: m_wid[g], unit: g});
                m_count++;
                m_busy[g] = 1'b0;
                m_ptr = (g + 1) % U;
            end
            if (pop) m_count--;
            if (legal_u >= 0) begin
                lat = int'(unit_lat[legal_u*LAT_W +: LAT_W]);
                if (lat == 0) lat = 1;
                m_busy[legal_u]    = 1'b1;
                m_wid[legal_u]     = int'(disp_warp_id);
                m_done_at[legal_u] = edge_n + lat + 1;
            end
            edge_n++;
        end
    end

    function automatic logic [U-1:0] model_avail();
        logic [U-1:0] a;
        for (int u = 0; u < U; u++) a[u] = !m_busy[u];
        return a;
    endfunction

    function automatic bit model_idle();
        bit b = (m_count == 0);
        for (int u = 0; u < U; u++) if (m_busy[u]) b = 0;
        return b;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("unit_avail", 64'(unit_avail), 64'(model_avail()));
            chk("disp_err", 64'(disp_err), 64'(m_err));
            chk("wb_valid", 64'(wb_valid), 64'(m_count > 0));
            chk("cq_full", 64'(cq_full), 64'(m_count == D));
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_valid), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("wb_warp_id", 64'(wb_warp_id), 64'(e.wid));
                    chk("wb_unit", 64'(wb_unit), 64'(1) << e.unit);
                    if (wb_ready) begin
                        chk("sb_release", 64'(sb_release), 64'(1) << e.wid);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!(wb_valid && wb_ready)) chk("sb_release_idle", 64'(sb_release), 64'(0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dispatch(input int w, input logic [U-1:0] un);
        disp_valid   = 1'b1;
        disp_warp_id = WID'(w);
        disp_unit    = un;
        cyc(1);
        disp_valid   = 1'b0;
    endtask

    task automatic set_lat(input int u, input int l);
        unit_lat[u*LAT_W +: LAT_W] = LAT_W'(l);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        wb_ready = 1'b1;
        while (!model_idle() && n < 300) begin
            cyc(1);
            n++;
        end
        chk("drain_done", 64'(model_idle()), 64'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1;
        chk("rst_avail", 64'(unit_avail), 64'h3f);
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_sb_release", 64'(sb_release), 64'(0));
        chk("rst_cq_full", 64'(cq_full), 64'(0));
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // single dispatch, latency 3
        set_lat(2, 3);
        wb_ready = 1'b1;
        dispatch(5, 6'b000100);
        cyc(8);

        // zero latency behaves as one
        set_lat(0, 0);
        dispatch(9, 6'b000001);
        cyc(5);

        // busy and illegal-unit rejection
        set_lat(1, 6);
        dispatch(3, 6'b000010);
        dispatch(4, 6'b000010);
        dispatch(7, 6'b000011);
        dispatch(8, 6'b000000);
        drain();

        // simultaneous completion with pointer at 0
        do_reset();
        set_lat(0, 3);
        set_lat(3, 2);
        set_lat(5, 1);
        dispatch(10, 6'b000001);
        dispatch(11, 6'b001000);
        dispatch(12, 6'b100000);
        cyc(8);

        // backpressure on a two-entry queue
        wb_ready = 1'b0;
        for (int u = 0; u < 3; u++) set_lat(u, 1);
        dispatch(20, 6'b000001);
        dispatch(21, 6'b000010);
        dispatch(22, 6'b000100);
        cyc(6);
        chk("bp_full", 64'(cq_full), 64'(1));
        chk("bp_hold_avail", 64'(unit_avail[2]), 64'(0));
        drain();

        // reset with work in flight
        wb_ready = 1'b0;
        set_lat(0, 9);
        set_lat(1, 9);
        set_lat(4, 1);
        dispatch(1, 6'b010000);
        dispatch(2, 6'b000001);
        dispatch(6, 6'b000010);
        cyc(2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_avail", 64'(unit_avail), 64'h3f);
        chk("midrst_wb_valid", 64'(wb_valid), 64'(0));
        chk("midrst_cq_full", 64'(cq_full), 64'(0));
        cyc(2);
        rst = 1'b1;
        wb_ready = 1'b1;
        cyc(12);

        // randomized traffic
        for (int u = 0; u < U; u++) set_lat(u, int'($urandom_range(0, 7)));
        for (int i = 0; i < 1500; i++) begin
            disp_valid   = ($urandom % 2) == 0;
            disp_warp_id = WID'($urandom);
            if (($urandom % 8) == 0) disp_unit = U'($urandom);
            else                     disp_unit = U'(1) << ($urandom % U);
            wb_ready = ($urandom % 4) != 0;
            cyc(1);
        end
        disp_valid = 1'b0;
        drain();
        cyc(2);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
